// File: rtl/katp91_pkg.sv
// Shared op encodings and word width for the pointer-step datapath.
package katp91_pkg;
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;
    localparam int         WORD_W  = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_i+1, wrapping mod N.
// Zero latency; no backpressure, any_o simply drops when nothing is requesting.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic found;
    int   cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
        any_o = found;
    end
endmodule

// File: rtl/pointer_step_arbiter.sv
// Shared inc/dec/load unit for NREQ pointer registers, round-robin, one op per cycle.
// Result registered: req->ack 1 cycle uncontended, worst wait NREQ-1 cycles; req held until ack.
module pointer_step_arbiter
    import katp91_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [2*NREQ-1:0]     op_i,
    input  logic [NREQ-1:0]       post_i,
    input  logic [NREQ*WIDTH-1:0] load_data_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  wrap_o,
    output logic [NREQ*WIDTH-1:0] ptr_out_o,
    output logic                  busy_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [WIDTH-1:0] ptr_q [NREQ];
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wrap_q, wrap_d;
    logic [IW-1:0]    last_q;

    logic [NREQ-1:0]  elig, grant;
    logic [IW-1:0]    gidx;
    logic             any;
    logic [1:0]       g_op;
    logic             g_post, is_inc, is_dec;
    logic [WIDTH-1:0] g_load, old_p, sum_p, ptr_d;

    // A requester being acked this cycle is masked so its still-held req is not issued twice.
    assign elig   = req_i & ~ack_q;
    assign busy_o = |elig;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req_i   (elig),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (any)
    );

    always_comb begin
        g_op   = op_i[2*gidx +: 2];
        g_post = post_i[gidx];
        g_load = load_data_i[gidx*WIDTH +: WIDTH];
        old_p  = ptr_q[gidx];
        is_inc = (g_op == OP_INC);
        is_dec = (g_op == OP_DEC);
        // Single adder: +all-ones is -1 for dec, +1 for inc, +0 otherwise.
        sum_p  = old_p + ({WIDTH{is_dec}} | {{(WIDTH-1){1'b0}}, is_inc});
        unique case (g_op)
            OP_READ: ptr_d = old_p;
            OP_LOAD: ptr_d = g_load;
            default: ptr_d = sum_p;
        endcase
        wrap_d  = any & ((is_inc & (&old_p)) | (is_dec & ~(|old_p)));
        ack_d   = any ? grant : '0;
        rdata_d = any ? (g_post ? old_p : ptr_d) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREQ; i++) ptr_q[i] <= RESET_VAL;
            ack_q   <= '0;
            rdata_q <= '0;
            wrap_q  <= 1'b0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            wrap_q  <= wrap_d;
            if (any) begin
                ptr_q[gidx] <= ptr_d;
                last_q      <= gidx;
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_ptr_out
        assign ptr_out_o[i*WIDTH +: WIDTH] = ptr_q[i];
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign wrap_o  = wrap_q;
endmodule

// File: tb/tb_pointer_step_arbiter.sv
// Scenario tasks plus a randomized run, all checked against an arithmetic reference model.
module tb_pointer_step_arbiter;
    import katp91_pkg::*;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int VW   = NREQ + W + 1 + NREQ*W;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req, post;
    logic [2*NREQ-1:0]   op;
    logic [NREQ*W-1:0]   ld;
    logic [NREQ-1:0]     ack;
    logic [W-1:0]        rdata;
    logic                wrap;
    logic [NREQ*W-1:0]   ptr_out;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    int              m_ptr [NREQ];
    int              m_last;
    logic [NREQ-1:0] m_ack;
    int              exp_rdata;
    logic            exp_wrap;

    pointer_step_arbiter #(.NREQ(NREQ), .WIDTH(W), .RESET_VAL(16'h0000)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .op_i        (op),
        .post_i      (post),
        .load_data_i (ld),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .wrap_o      (wrap),
        .ptr_out_o   (ptr_out),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Reference: what one clock edge does to the pointer file, in plain integer arithmetic.
    function automatic void model_edge();
        int w, old, nw;
        w = -1;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) m_ptr[i] = 0;
            m_last = NREQ - 1; m_ack = '0; exp_rdata = 0; exp_wrap = 1'b0;
            return;
        end
        for (int k = 1; k <= NREQ; k++) begin
            int c = (m_last + k) % NREQ;
            if (w < 0 && req[c] && !m_ack[c]) w = c;
        end
        m_ack = '0; exp_rdata = 0; exp_wrap = 1'b0;
        if (w >= 0) begin
            old = m_ptr[w];
            nw  = old;
            case (op[2*w +: 2])
                OP_INC:  begin nw = old + 1; if (nw == 65536) begin nw = 0; exp_wrap = 1'b1; end end
                OP_DEC:  begin nw = old - 1; if (nw < 0) begin nw = 65535; exp_wrap = 1'b1; end end
                OP_LOAD: nw = int'(ld[w*W +: W]);
                default: nw = old;
            endcase
            m_ptr[w]  = nw;
            exp_rdata = post[w] ? old : nw;
            m_ack[w]  = 1'b1;
            m_last    = w;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NREQ*W-1:0] p;
        for (int i = 0; i < NREQ; i++) p[i*W +: W] = W'(m_ptr[i]);
        return {m_ack, W'(exp_rdata), exp_wrap, p};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [1:0] o, input logic p, input logic [W-1:0] d);
        req = '0;
        req[i] = 1'b1;
        op[2*i +: 2] = o;
        post[i] = p;
        ld[i*W +: W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; op = '0; post = '0; ld = '0;
        tick();
        rst = 1'b0;
        n_vec++;
        if (ack !== '0 || rdata !== '0 || wrap !== 1'b0 || ptr_out !== '0) begin
            n_err++;
            $display("FAIL reset_state ack=%b rdata=%h wrap=%b ptr=%h, need all zero", ack, rdata, wrap, ptr_out);
        end
        drive(0, OP_INC, 1'b1, '0);
        tick();
        req = '0;
        n_vec++;
        if (ack !== 4'b0001 || rdata !== 16'h0000 || ptr_out[15:0] !== 16'h0001) begin
            n_err++;
            $display("FAIL first_inc ack=%b rdata=%h ptr0=%h, need 0001/0000/0001", ack, rdata, ptr_out[15:0]);
        end
        n_vec++;
        if ({ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++;
            $display("FAIL first_inc_model got=%h need=%h", {ack, rdata, wrap, ptr_out}, exp_vec());
        end
        tick();
        n_vec++;
        if (ack !== '0) begin n_err++; $display("FAIL idle_after_ack ack=%b need 0000", ack); end
    endtask

    task automatic test_contention();
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'hF; op = 8'b01010101; post = '0;
        for (int k = 0; k < NREQ; k++) begin
            tick();
            n_vec++;
            if (ack !== (4'b0001 << k) || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
                n_err++;
                $display("FAIL contention_order step=%0d ack=%b need=%b", k, ack, 4'b0001 << k);
            end
            req = req & ~ack;
        end
        n_vec++;
        if (ptr_out !== {4{16'h0001}}) begin n_err++; $display("FAIL contention_ptrs got=%h need all 0001", ptr_out); end
        drive(1, OP_READ, 1'b0, '0);
        tick(); req = '0; tick();
        req = 4'b1001; op[1:0] = OP_INC; op[7:6] = OP_INC;
        tick();
        n_vec++;
        if (ack !== 4'b1000 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL rr_after_1_first ack=%b need 1000", ack);
        end
        req[3] = 1'b0;
        tick();
        n_vec++;
        if (ack !== 4'b0001 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL rr_after_1_second ack=%b need 0001", ack);
        end
        req = '0; tick();
    endtask

    task automatic test_wrap();
        drive(2, OP_LOAD, 1'b0, 16'hFFFF); tick(); req = '0; tick();
        drive(2, OP_INC, 1'b0, '0); tick(); req = '0;
        n_vec++;
        if (rdata !== 16'h0000 || wrap !== 1'b1 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL wrap_inc rdata=%h wrap=%b, need 0000/1", rdata, wrap);
        end
        tick();
        drive(2, OP_DEC, 1'b0, '0); tick(); req = '0;
        n_vec++;
        if (rdata !== 16'hFFFF || wrap !== 1'b1 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL wrap_dec rdata=%h wrap=%b, need FFFF/1", rdata, wrap);
        end
        tick();
    endtask

    task automatic test_push_pop();
        drive(1, OP_LOAD, 1'b0, 16'h1000); tick(); req = '0; tick();
        drive(1, OP_DEC, 1'b0, '0); tick(); req = '0;
        n_vec++;
        if (rdata !== 16'h0FFF || wrap !== 1'b0 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL push rdata=%h wrap=%b, need 0FFF/0", rdata, wrap);
        end
        tick();
        drive(1, OP_INC, 1'b1, '0); tick(); req = '0;
        n_vec++;
        if (rdata !== 16'h0FFF || ptr_out[31:16] !== 16'h1000 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL pop rdata=%h ptr1=%h, need 0FFF/1000", rdata, ptr_out[31:16]);
        end
        tick();
    endtask

    task automatic test_held_req();
        logic [W-1:0] base;
        logic [NREQ-1:0] need;
        base = ptr_out[15:0];
        drive(0, OP_INC, 1'b0, '0);
        for (int t = 1; t <= 3; t++) begin
            tick();
            need = (t == 2) ? 4'b0000 : 4'b0001;
            n_vec++;
            if (ack !== need || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
                n_err++; $display("FAIL held_req t=%0d ack=%b need=%b", t, ack, need);
            end
        end
        req = '0;
        n_vec++;
        if (ptr_out[15:0] !== base + 16'd2) begin
            n_err++; $display("FAIL held_req_ptr got=%h need=%h", ptr_out[15:0], base + 16'd2);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        drive(1, OP_LOAD, 1'b0, 16'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        n_vec++;
        if (ack !== '0 || ptr_out[31:16] !== 16'h0000) begin
            n_err++; $display("FAIL reset_mid_op ack=%b ptr1=%h, need 0000/0000", ack, ptr_out[31:16]);
        end
        tick();
        n_vec++;
        if (ack !== '0 || {ack, rdata, wrap, ptr_out} !== exp_vec()) begin
            n_err++; $display("FAIL reset_mid_op_after ack=%b need 0000", ack);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req  = NREQ'($urandom);
            op   = (2*NREQ)'($urandom);
            post = NREQ'($urandom);
            ld   = {$urandom, $urandom};
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) == 0) ld[i*W +: W] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
            #1;
            n_vec++;
            if (busy !== |(req & ~m_ack)) begin
                n_err++; $display("FAIL random_busy cyc=%0d got=%b need=%b", n, busy, |(req & ~m_ack));
            end
            tick();
            n_vec++;
            if ({ack, rdata, wrap, ptr_out} !== exp_vec()) begin
                n_err++; $display("FAIL random_model cyc=%0d got=%h need=%h", n, {ack, rdata, wrap, ptr_out}, exp_vec());
            end
        end
        rst = 1'b0; req = '0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_wrap();
        test_push_pop();
        test_held_req();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
